// File: rtl/alu_seq_if.sv
// Operand/result bus between the register file side and the sequential ALU.
// The master drives the request and operands; the slave returns results and handshake.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [2:0]       sel_in;
    logic             carry_in;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             zero_out;
    logic             busy;
    logic             done;

    modport master (
        output start, in_A, in_B, sel_in, carry_in,
        input  out, carry_out, zero_out, busy, done
    );

    modport slave (
        input  start, in_A, in_B, sel_in, carry_in,
        output out, carry_out, zero_out, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic, bit-serial shift-left and
// shift-add multiply, with registered result/flags and start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int KW = $clog2(WIDTH);
    localparam int CW = KW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic               is_mul_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   out_r;
    logic               carry_r;
    logic               zero_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   res_s;
    logic               res_carry_s;
    logic [KW-1:0]      k_s;
    logic [WIDTH-1:0]   shl_next_s;
    logic [2*WIDTH-1:0] mul_acc_s;

    // Single-cycle result and carry from the live bus operands.
    always_comb begin
        sum_s       = {1'b0, bus.in_A} + {1'b0, bus.in_B} + {{WIDTH{1'b0}}, bus.carry_in};
        diff_s      = {1'b0, bus.in_A} + {1'b0, ~bus.in_B} + {{WIDTH{1'b0}}, bus.carry_in};
        k_s         = bus.in_B[KW-1:0];
        res_s       = bus.in_A;
        res_carry_s = 1'b0;
        case (bus.sel_in)
            3'b000: begin
                res_s       = diff_s[WIDTH-1:0];
                res_carry_s = diff_s[WIDTH];
            end
            3'b001:  res_s = bus.in_A & bus.in_B;
            3'b010:  res_s = bus.in_A | bus.in_B;
            3'b011: begin
                res_s       = sum_s[WIDTH-1:0];
                res_carry_s = sum_s[WIDTH];
            end
            3'b100:  res_s = bus.in_A ^ bus.in_B;
            3'b101:  res_s = bus.in_A;
            3'b110:  res_s = {WIDTH{1'b0}};
            3'b111:  res_s = bus.in_A;
            default: res_s = bus.in_A;
        endcase
    end

    // One iteration of the shift and multiply datapaths on latched operands.
    always_comb begin
        shl_next_s = {a_r[WIDTH-2:0], 1'b0};
        if (b_r[0]) begin
            mul_acc_s = acc_r + mcand_r;
        end else begin
            mul_acc_s = acc_r;
        end
    end

    // Control FSM with result/flag registers; results are only written on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            is_mul_r <= 1'b0;
            count_r  <= {CW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            out_r    <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.sel_in == 3'b101 && k_s != {KW{1'b0}}) begin
                            a_r      <= bus.in_A;
                            count_r  <= {1'b0, k_s};
                            is_mul_r <= 1'b0;
                            busy_r   <= 1'b1;
                            state_r  <= RUN;
                        end else if (bus.sel_in == 3'b110) begin
                            mcand_r  <= {{WIDTH{1'b0}}, bus.in_A};
                            b_r      <= bus.in_B;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            count_r  <= CW'(WIDTH);
                            is_mul_r <= 1'b1;
                            busy_r   <= 1'b1;
                            state_r  <= RUN;
                        end else begin
                            out_r   <= res_s;
                            carry_r <= res_carry_s;
                            zero_r  <= (res_s == {WIDTH{1'b0}});
                            done_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    count_r <= count_r - CW'(1);
                    if (is_mul_r) begin
                        acc_r   <= mul_acc_s;
                        mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
                        b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    end else begin
                        a_r <= shl_next_s;
                    end
                    if (count_r == CW'(1)) begin
                        if (is_mul_r) begin
                            out_r   <= mul_acc_s[WIDTH-1:0];
                            carry_r <= |mul_acc_s[2*WIDTH-1:WIDTH];
                            zero_r  <= (mul_acc_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        end else begin
                            out_r   <= shl_next_s;
                            carry_r <= a_r[WIDTH-1];
                            zero_r  <= (shl_next_s == {WIDTH{1'b0}});
                        end
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.carry_out = carry_r;
    assign bus.zero_out  = zero_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_alu_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(4)) b4 ();
    alu_seq_if #(.WIDTH(8)) b8 ();

    alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: issues start there, returns at the negedge of the done cycle.
    task automatic run_op(input bit wide, input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input int lat,
                          output logic [7:0] o, output logic c, output logic z);
        logic d, bz;
        o = 8'h00; c = 1'b0; z = 1'b0;
        if (wide) begin
            b8.start = 1'b1; b8.sel_in = sel; b8.in_A = a; b8.in_B = b; b8.carry_in = cin;
        end else begin
            b4.start = 1'b1; b4.sel_in = sel; b4.in_A = a[3:0]; b4.in_B = b[3:0]; b4.carry_in = cin;
        end
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == 1) begin
                b4.start = 1'b0;
                b8.start = 1'b0;
            end
            d  = wide ? b8.done : b4.done;
            bz = wide ? b8.busy : b4.busy;
            if (i < lat) begin
                check_eq("busy_running", {15'd0, bz}, 16'd1);
                check_eq("done_early", {15'd0, d}, 16'd0);
            end else begin
                check_eq("done_at_latency", {15'd0, d}, 16'd1);
                check_eq("busy_at_done", {15'd0, bz}, 16'd0);
                o = wide ? b8.out : {4'h0, b4.out};
                c = wide ? b8.carry_out : b4.carry_out;
                z = wide ? b8.zero_out : b4.zero_out;
            end
        end
    endtask

    logic [7:0] o;
    logic       c, z;
    int         ndone, done_cyc;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        b4.start = 1'b0; b4.in_A = 4'h0; b4.in_B = 4'h0; b4.sel_in = 3'b000; b4.carry_in = 1'b0;
        b8.start = 1'b0; b8.in_A = 8'h00; b8.in_B = 8'h00; b8.sel_in = 3'b000; b8.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out4", {12'd0, b4.out}, 16'd0);
        check_eq("rst_flags4", {13'd0, b4.carry_out, b4.zero_out, b4.busy}, 16'd0);
        check_eq("rst_done4", {15'd0, b4.done}, 16'd0);
        check_eq("rst_out8", {8'd0, b8.out}, 16'd0);
        check_eq("rst_flags8", {12'd0, b8.carry_out, b8.zero_out, b8.busy, b8.done}, 16'd0);

        // WIDTH=4 single-cycle and shift ops, issued back to back
        run_op(1'b0, 3'b011, 8'h5, 8'h3, 1'b0, 1, o, c, z);
        check_eq("add4", {8'd0, o}, 16'h0008);
        check_eq("add4_flags", {14'd0, c, z}, 16'd0);
        run_op(1'b0, 3'b000, 8'h3, 8'h5, 1'b1, 1, o, c, z);
        check_eq("sub4_borrow", {8'd0, o}, 16'h000E);
        check_eq("sub4_borrow_flags", {14'd0, c, z}, 16'd0);
        run_op(1'b0, 3'b000, 8'h5, 8'h5, 1'b1, 1, o, c, z);
        check_eq("sub4_zero", {8'd0, o}, 16'h0000);
        check_eq("sub4_zero_flags", {14'd0, c, z}, 16'd3);
        run_op(1'b0, 3'b001, 8'hC, 8'hA, 1'b1, 1, o, c, z);
        check_eq("and4", {7'd0, o, c}, {7'd0, 8'h08, 1'b0});
        run_op(1'b0, 3'b010, 8'hC, 8'hA, 1'b0, 1, o, c, z);
        check_eq("or4", {7'd0, o, c}, {7'd0, 8'h0E, 1'b0});
        run_op(1'b0, 3'b101, 8'hB, 8'h2, 1'b0, 3, o, c, z);
        check_eq("shl4_k2", {7'd0, o, c}, {7'd0, 8'h0C, 1'b0});
        run_op(1'b0, 3'b101, 8'hB, 8'h4, 1'b0, 1, o, c, z);
        check_eq("shl4_k0", {6'd0, o, c, z}, {6'd0, 8'h0B, 2'b00});
        run_op(1'b0, 3'b101, 8'hB, 8'h3, 1'b0, 4, o, c, z);
        check_eq("shl4_k3", {7'd0, o, c}, {7'd0, 8'h08, 1'b1});

        // MUL with a PASS start issued while busy
        @(negedge clk);
        b4.start = 1'b1; b4.sel_in = 3'b110; b4.in_A = 4'h7; b4.in_B = 4'h3; b4.carry_in = 1'b0;
        ndone = 0; done_cyc = 0; o = 8'h00; c = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (b4.done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = i;
                    o = {4'h0, b4.out};
                    c = b4.carry_out;
                end
            end
            if (i <= 4) check_eq("mul_busy", {15'd0, b4.busy}, 16'd1);
            if (i == 1) b4.start = 1'b0;
            if (i == 2) begin
                b4.start = 1'b1; b4.sel_in = 3'b111; b4.in_A = 4'h7; b4.in_B = 4'h0;
            end
            if (i == 3) b4.start = 1'b0;
        end
        check_eq("mul_done_cycle", done_cyc[15:0], 16'd5);
        check_eq("mul_done_count", ndone[15:0], 16'd1);
        check_eq("mul4", {7'd0, o, c}, {7'd0, 8'h05, 1'b1});
        check_eq("mul4_held", {12'd0, b4.out}, 16'h0005);

        // Reset in the middle of a MUL
        @(negedge clk);
        b4.start = 1'b1; b4.sel_in = 3'b110; b4.in_A = 4'h5; b4.in_B = 4'h6;
        @(negedge clk);
        b4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_out", {12'd0, b4.out}, 16'd0);
        check_eq("midrst_flags", {13'd0, b4.carry_out, b4.zero_out, b4.busy}, 16'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b4.done) ndone++;
        end
        check_eq("midrst_no_done", ndone[15:0], 16'd0);
        run_op(1'b0, 3'b011, 8'h1, 8'h2, 1'b1, 1, o, c, z);
        check_eq("add4_after_rst", {7'd0, o, c}, {7'd0, 8'h04, 1'b0});

        // WIDTH=8 ops, back to back
        run_op(1'b1, 3'b011, 8'hFF, 8'h01, 1'b0, 1, o, c, z);
        check_eq("add8_wrap", {6'd0, o, c, z}, {6'd0, 8'h00, 2'b11});
        run_op(1'b1, 3'b100, 8'hC3, 8'h0F, 1'b0, 1, o, c, z);
        check_eq("xor8", {6'd0, o, c, z}, {6'd0, 8'hCC, 2'b00});
        run_op(1'b1, 3'b111, 8'hA5, 8'h3C, 1'b1, 1, o, c, z);
        check_eq("pass8", {6'd0, o, c, z}, {6'd0, 8'hA5, 2'b00});
        run_op(1'b1, 3'b000, 8'h00, 8'h01, 1'b1, 1, o, c, z);
        check_eq("sub8_under", {6'd0, o, c, z}, {6'd0, 8'hFF, 2'b00});
        run_op(1'b1, 3'b110, 8'h10, 8'h11, 1'b0, 9, o, c, z);
        check_eq("mul8", {6'd0, o, c, z}, {6'd0, 8'h10, 2'b10});
        @(negedge clk);
        check_eq("done8_one_cycle", {15'd0, b8.done}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential successor to the HC4e combinational 4-bit ALU. It keeps the existing `sel_in` encodings for ADD (011), XOR (100) and pass-through (111), and adds the remaining codes. Operand width is a parameter. Results and flags are registered, and a start/busy/done handshake supports multi-cycle shift and multiply operations. It sits between the register file and the accumulator/flag writeback of the next-generation core.

## Interface
- `WIDTH`, default 4: operand/result width; must be a power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; accepted only when `busy`=0.
- `in_A`  in  WIDTH  operand A; captured on an accepted `start`.
- `in_B`  in  WIDTH  operand B; captured on an accepted `start`.
- `sel_in`  in  3  operation select; captured on an accepted `start`.
- `carry_in`  in  1  carry input (ADD, SUB); captured on an accepted `start`.
- `out`  out  WIDTH  registered result.
- `carry_out`  out  1  registered carry flag.
- `zero_out`  out  1  registered; 1 when the `out` value written with `done` is all zeros.
- `busy`  out  1  1 while a multi-cycle operation runs.
- `done`  out  1  one-cycle pulse when `out`, `carry_out` and `zero_out` update.

## Operation
- `sel_in` encodings:
  - 000 SUB: `A + ~B + carry_in`. `carry_in`=1 means no borrow in. `carry_out` = bit WIDTH of the sum (0 = borrow).
  - 001 AND. `carry_out`=0.
  - 010 OR. `carry_out`=0.
  - 011 ADD: `A + B + carry_in`. `carry_out` = bit WIDTH of the sum.
  - 100 XOR. `carry_out`=0.
  - 101 SHL:
    - Shift A left by k = `B[$clog2(WIDTH)-1:0]` (upper B bits ignored); LSB fills with 0.
    - Runs one bit per cycle.
    - `carry_out` = last bit shifted out of the MSB; 0 if k=0.
  - 110 MUL:
    - Unsigned A×B, shift-add, one B bit per cycle, LSB first, 2·WIDTH-bit accumulator.
    - `out` = low WIDTH bits of the product.
    - `carry_out` = OR of the high WIDTH bits (overflow).
  - 111 PASS: `out` = A. `carry_out`=0.
- All arithmetic is unsigned and modulo 2^WIDTH.
- Operands are latched at start. Input changes after acceptance have no effect on the running operation.
- FSM states:
  - IDLE: `busy`=0. On `start`:
    - single-cycle op, or SHL with k=0 → write results, pulse `done`, stay IDLE;
    - SHL with k>0 → RUN with count=k;
    - MUL → RUN with count=WIDTH.
  - RUN: `busy`=1. Each cycle performs one step and decrements count. When count reaches 0: write results, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored: no queueing, no effect on the running op.
- `out`, `carry_out` and `zero_out` hold their values between `done` pulses. Intermediate RUN values are never visible on `out`.
- Reset:
  - On reset: `out`=0, `carry_out`=0, `zero_out`=0, `busy`=0, `done`=0, state IDLE.
  - `rst` mid-operation aborts the operation; no `done` follows.
  - `rst` has priority over `start` in the same cycle.

## Timing
- All latencies are measured from the edge at which `start` is sampled (cycle N).
- Single-cycle ops, and SHL with k=0: results and `done` valid in cycle N+1; `busy` never asserts.
- SHL with k>0: `busy`=1 in cycles N+1..N+k; results and `done` in N+k+1, with `busy`=0 in that cycle.
- MUL: `busy`=1 in cycles N+1..N+WIDTH; results and `done` in N+WIDTH+1.
- A `start` asserted in a cycle with `done`=1 is accepted, so back-to-back ops have no bubble.
- `done` is exactly one cycle wide.

## Test plan
- WIDTH=4, ADD: A=0101, B=0011, cin=0 → cycle N+1: `out`=1000, `carry_out`=0, `zero_out`=0, `done`=1, `busy` stays 0.
- SUB:
  - A=0011, B=0101, cin=1 → `out`=1110, `carry_out`=0 (borrow).
  - Then A=0101, B=0101, cin=1 → `out`=0000, `carry_out`=1, `zero_out`=1.
- SHL: A=1011, B=0010 → `busy` in N+1..N+2; `done` in N+3 with `out`=1100, `carry_out`=0. Also B=0100 (k=0) → `out`=1011, `carry_out`=0, `done` at N+1.
- MUL with ignored start:
  - A=0111, B=0011 → `busy` in N+1..N+4; `done` at N+5 with `out`=0101, `carry_out`=1 (product 0x15).
  - A `start` with sel=111 at N+2 is ignored: no extra `done`, and `out` is not 0111.
- Reset: MUL started, `rst` pulsed at N+2 → cycle N+3: `out`=0, flags 0, `busy`=0; no `done` in the following 8 cycles. A new ADD is then accepted normally.
- WIDTH=8:
  - ADD A=FF, B=01, cin=0 → `out`=00, `carry_out`=1, `zero_out`=1.
  - XOR C3^0F → 0xCC.
  - PASS A=A5 → A5.
  - Back-to-back starts on consecutive `done` cycles each complete.
